// File: rtl/tagged_frame_demux.sv
// Splits tagged words into NCH payload channels, staging each frame in shadow
// registers and publishing it atomically on the commit tag; includes a link watchdog.
module tagged_frame_demux #(
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 4,
    parameter int NCH         = 7,
    parameter int COMMIT_TAG  = 15,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic [NCH*(DATA_W-TAG_W)-1:0]     ch_data,
    output logic [NCH-1:0]                    ch_upd,
    output logic [7:0]                        frame_cnt,
    output logic                              link_alive,
    output logic                              err_unknown_tag,
    output logic                              err_overrun
);
    localparam int PW = DATA_W - TAG_W;
    localparam logic [TAG_W-1:0] NCH_T    = TAG_W'(NCH);
    localparam logic [TAG_W-1:0] COMMIT_T = TAG_W'(COMMIT_TAG);
    localparam logic [CNT_W-1:0] WD_MAX   = CNT_W'(TIMEOUT_CYC);

    logic [NCH-1:0][PW-1:0] shadow_q, shadow_d;
    logic [NCH-1:0][PW-1:0] ch_data_q, ch_data_d;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0]         ch_upd_q, ch_upd_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]       wd_q, wd_d;
    logic                   alive_q, alive_d;
    logic                   err_unk_q, err_unk_d;
    logic                   err_ovr_q, err_ovr_d;

    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    payload;

    assign tag     = in_data[DATA_W-1 -: TAG_W];
    assign payload = in_data[PW-1:0];

    always_comb begin
        shadow_d    = shadow_q;
        ch_data_d   = ch_data_q;
        pending_d   = pending_q;
        ch_upd_d    = '0;
        frame_cnt_d = frame_cnt_q;
        wd_d        = wd_q;
        alive_d     = alive_q;
        err_unk_d   = 1'b0;
        err_ovr_d   = 1'b0;
        if (in_valid) begin
            // Any word, even an unrecognised one, proves the link is up.
            wd_d = '0;
            if (tag < NCH_T) begin
                for (int i = 0; i < NCH; i++) begin
                    if (tag == TAG_W'(i)) begin
                        err_ovr_d    = pending_q[i];
                        shadow_d[i]  = payload;
                        pending_d[i] = 1'b1;
                    end
                end
            end else if (tag == COMMIT_T) begin
                for (int i = 0; i < NCH; i++) begin
                    if (pending_q[i]) begin
                        ch_data_d[i] = shadow_q[i];
                    end
                end
                ch_upd_d    = pending_q;
                pending_d   = '0;
                frame_cnt_d = frame_cnt_q + 8'd1;
                alive_d     = 1'b1;
            end else begin
                err_unk_d = 1'b1;
            end
        end else if (wd_q < WD_MAX) begin
            wd_d = wd_q + CNT_W'(1);
            // Timeout edge: a stale partial frame must never be published later.
            if (wd_q == WD_MAX - CNT_W'(1)) begin
                alive_d   = 1'b0;
                pending_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            ch_data_q   <= '0;
            pending_q   <= '0;
            ch_upd_q    <= '0;
            frame_cnt_q <= '0;
            wd_q        <= '0;
            alive_q     <= 1'b0;
            err_unk_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            ch_data_q   <= ch_data_d;
            pending_q   <= pending_d;
            ch_upd_q    <= ch_upd_d;
            frame_cnt_q <= frame_cnt_d;
            wd_q        <= wd_d;
            alive_q     <= alive_d;
            err_unk_q   <= err_unk_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign ch_data         = ch_data_q;
    assign ch_upd          = ch_upd_q;
    assign frame_cnt       = frame_cnt_q;
    assign link_alive      = alive_q;
    assign err_unknown_tag = err_unk_q;
    assign err_overrun     = err_ovr_q;

endmodule

// File: tb/tb_tagged_frame_demux.sv
// Bench for tagged_frame_demux: directed frames plus random traffic, with an
// expectation queue filled by the driver and drained by an independent monitor.
module tb_tagged_frame_demux;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 4;
    localparam int NCH     = 7;
    localparam int COMMIT  = 15;
    localparam int TMO     = 10;
    localparam int PW      = DATA_W - TAG_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [DATA_W-1:0]      in_data = '0;
    logic                   in_valid = 1'b0;
    logic [NCH*PW-1:0]      ch_data;
    logic [NCH-1:0]         ch_upd;
    logic [7:0]             frame_cnt;
    logic                   link_alive;
    logic                   err_unknown_tag;
    logic                   err_overrun;

    tagged_frame_demux #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .NCH(NCH), .COMMIT_TAG(COMMIT),
        .TIMEOUT_CYC(TMO), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .ch_data(ch_data), .ch_upd(ch_upd), .frame_cnt(frame_cnt),
        .link_alive(link_alive), .err_unknown_tag(err_unknown_tag),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*PW-1:0] data;
        logic [NCH-1:0]    upd;
        logic [7:0]        fc;
        logic              alive;
        logic              eu;
        logic              eo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: what the receiving logic should see, in plain terms.
    int unsigned m_shadow[NCH];
    bit          m_pend[NCH];
    int unsigned m_pub[NCH];
    int          m_frames = 0;
    bit          m_alive  = 0;
    int          m_idle   = 0;

    task automatic model_step(input bit r, input bit v, input logic [DATA_W-1:0] d, output exp_t e);
        int t;
        e.upd = '0;
        e.eu  = 1'b0;
        e.eo  = 1'b0;
        t = int'(d[DATA_W-1 -: TAG_W]);
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = 0; m_pend[i] = 0; m_pub[i] = 0;
            end
            m_frames = 0; m_alive = 0; m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (t < NCH) begin
                if (m_pend[t]) e.eo = 1'b1;
                m_shadow[t] = int'(d[PW-1:0]);
                m_pend[t]   = 1;
            end else if (t == COMMIT) begin
                for (int i = 0; i < NCH; i++) begin
                    if (m_pend[i]) begin
                        m_pub[i] = m_shadow[i];
                        e.upd[i] = 1'b1;
                    end
                    m_pend[i] = 0;
                end
                m_frames = (m_frames + 1) % 256;
                m_alive  = 1;
            end else begin
                e.eu = 1'b1;
            end
        end else if (m_idle < TMO) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_alive = 0;
                for (int i = 0; i < NCH; i++) m_pend[i] = 0;
            end
        end
        for (int i = 0; i < NCH; i++) e.data[i*PW +: PW] = PW'(m_pub[i]);
        e.fc    = 8'(m_frames);
        e.alive = m_alive;
    endtask

    task automatic cycle(input bit r, input bit v, input logic [DATA_W-1:0] d);
        exp_t e;
        rst      = r;
        in_valid = v;
        in_data  = d;
        model_step(r, v, d, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic word(input logic [DATA_W-1:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ch_data",   128'(ch_data),         128'(e.data));
                chk("ch_upd",    128'(ch_upd),          128'(e.upd));
                chk("frame_cnt", 128'(frame_cnt),       128'(e.fc));
                chk("link_alive",128'(link_alive),      128'(e.alive));
                chk("err_unk",   128'(err_unknown_tag), 128'(e.eu));
                chk("err_ovr",   128'(err_overrun),     128'(e.eo));
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin : stim
        int r;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);

        // First frame, overrun, unknown tag.
        word(16'h0123); word(16'h1456); word(16'hF000); idle(1);
        word(16'h2111); word(16'h2222); word(16'hF000); idle(1);
        word(16'h7ABC); word(16'hF000); idle(1);

        // Watchdog: timeout drops the partial frame; a late word still rescues the link.
        word(16'hF000); word(16'h3555); idle(10); word(16'hF000); idle(1);
        word(16'hF000); idle(9); word(16'h5001); idle(5);
        word(16'hF000); idle(8); word(16'h6002); idle(9); word(16'hF000); idle(2);

        // frame_cnt wrap from reset.
        cycle(1'b1, 1'b0, '0);
        for (int k = 0; k < 256; k++) word(16'hF000);
        idle(1);

        // Reset in the middle of a frame.
        word(16'h4777); cycle(1'b1, 1'b0, '0); word(16'hF000); idle(1);

        // Random traffic, including long gaps and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                cycle(1'b1, 1'b0, '0);
            end else if (r < 4) begin
                idle($urandom_range(8, 13));
            end else if (r < 65) begin
                r = $urandom_range(0, 9);
                if (r < 7)
                    word({4'($urandom_range(0, NCH-1)), 12'($urandom)});
                else if (r < 9)
                    word({4'(COMMIT), 12'($urandom)});
                else
                    word({4'($urandom_range(NCH, COMMIT-1)), 12'($urandom)});
            end else begin
                idle(1);
            end
        end
        idle(1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
